arb_mux: RTL and testbench

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 142 ++++++++++++++
 tb/tb_arb_mux.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// Round-robin N:1 arbiter with a registered output slice.
// Optional packet locking is enabled by defining ARB_MUX_LOCK_EN, which adds
// the last_i port and holds the grant on one channel until its last beat.
module arb_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         valid_i,
    input  logic [N*WIDTH-1:0]   data_i,
`ifdef ARB_MUX_LOCK_EN
    input  logic [N-1:0]         last_i,
`endif
    output logic [N-1:0]         ready_o,
    output logic                 valid_o,
    output logic [WIDTH-1:0]     data_o,
    output logic [$clog2(N)-1:0] sel_o,
    input  logic                 ready_i
);

    localparam int unsigned SW = $clog2(N);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [SW-1:0]    ptr_q, ptr_d;
`ifdef ARB_MUX_LOCK_EN
    logic             lock_q, lock_d;
    logic [SW-1:0]    lock_sel_q, lock_sel_d;
`endif

    logic          load;
    logic          cand_found;
    logic [SW-1:0] cand_idx;
    logic          grant;

    // Channel index base+off modulo N; off < N so one subtraction suffices.
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base,
                                               input int unsigned off);
        int unsigned s;
        s = int'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return SW'(s);
    endfunction

    // Increment with explicit wrap so non-power-of-two N never exceeds N-1.
    function automatic logic [SW-1:0] next_ptr(input logic [SW-1:0] idx);
        return (idx == SW'(N - 1)) ? '0 : idx + SW'(1);
    endfunction

    assign load = !valid_q || ready_i;

    // Pick the first requesting channel starting at ptr (or the locked one).
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!cand_found && valid_i[wrap_add(ptr_q, i)]) begin
                cand_found = 1'b1;
                cand_idx   = wrap_add(ptr_q, i);
            end
        end
`ifdef ARB_MUX_LOCK_EN
        if (lock_q) begin
            cand_found = valid_i[lock_sel_q];
            cand_idx   = lock_sel_q;
        end
`endif
    end

    // Ready is a one-hot grant, forced low while reset is asserted.
    always_comb begin
        grant = load && cand_found && rst_n;
        for (int unsigned k = 0; k < N; k++) begin
            ready_o[k] = grant && (cand_idx == SW'(k));
        end
    end

    // Next state of the output slice, round-robin pointer and lock.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef ARB_MUX_LOCK_EN
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
`endif
        if (load) begin
            if (grant) begin
                valid_d = 1'b1;
                data_d  = data_i[cand_idx*WIDTH +: WIDTH];
                sel_d   = cand_idx;
`ifdef ARB_MUX_LOCK_EN
                if (last_i[cand_idx]) begin
                    lock_d = 1'b0;
                    ptr_d  = next_ptr(cand_idx);
                end else begin
                    lock_d     = 1'b1;
                    lock_sel_d = cand_idx;
                end
`else
                ptr_d = next_ptr(cand_idx);
`endif
            end else begin
                // Nothing to send: drop valid but keep the last data/sel.
                valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
`ifdef ARB_MUX_LOCK_EN
            lock_q     <= 1'b0;
            lock_sel_q <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef ARB_MUX_LOCK_EN
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sel_o   = sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux (N=4, WIDTH=32): directed vector table,
// hand-written reset/lock sequences and a randomized run against a model.
module tb_arb_mux;

    localparam int NC = 4;
    localparam int W  = 32;
`ifdef ARB_MUX_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   valid_i;
    logic [NC*W-1:0] data_i;
    logic [NC-1:0]   last_i;
    logic [NC-1:0]   ready_o;
    logic            valid_o;
    logic [W-1:0]    data_o;
    logic [1:0]      sel_o;
    logic            ready_i;

    int checks = 0;
    int errors = 0;

    arb_mux #(
        .WIDTH (W),
        .N     (NC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .data_i  (data_i),
`ifdef ARB_MUX_LOCK_EN
        .last_i  (last_i),
`endif
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .sel_o   (sel_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle from a negedge: check ready_o before the edge and the
    // registered outputs just after it, then return on the next negedge.
    task automatic apply(input logic [3:0] v, input logic [NC*W-1:0] d, input logic r,
                         input logic [3:0] l, input logic [3:0] e_rdy, input logic e_val,
                         input logic [31:0] e_dat, input logic [1:0] e_sel, input string tag);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        last_i  = l;
        #1;
        chk({tag, " ready_o"}, 64'(ready_o), 64'(e_rdy));
        @(posedge clk);
        #1;
        chk({tag, " valid_o"}, 64'(valid_o), 64'(e_val));
        chk({tag, " data_o"}, 64'(data_o), 64'(e_dat));
        chk({tag, " sel_o"}, 64'(sel_o), 64'(e_sel));
        @(negedge clk);
    endtask

    // Behavioural reference: output slot plus rotating priority pointer.
    logic        m_valid;
    logic [31:0] m_data;
    int          m_sel, m_ptr, m_lock_ch;
    bit          m_lock;

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_sel     = 0;
        m_ptr     = 0;
        m_lock    = 1'b0;
        m_lock_ch = 0;
    endtask

    task automatic model_step(input logic [3:0] v, input logic [NC*W-1:0] d, input logic r,
                              input logic [3:0] l, output logic [3:0] e_rdy,
                              output logic e_val, output logic [31:0] e_dat,
                              output logic [1:0] e_sel);
        int g = -1;
        if (!m_valid || r) begin
            if (m_lock) begin
                if (v[m_lock_ch]) g = m_lock_ch;
            end else begin
                for (int off = 0; off < NC; off++) begin
                    if (g < 0 && v[(m_ptr + off) % NC]) g = (m_ptr + off) % NC;
                end
            end
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = d[g*W +: W];
                m_sel   = g;
                if (LOCK && !l[g]) begin
                    m_lock    = 1'b1;
                    m_lock_ch = g;
                end else begin
                    m_lock = 1'b0;
                    m_ptr  = (g + 1) % NC;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
        e_rdy = (g >= 0) ? 4'(1 << g) : 4'h0;
        e_val = m_valid;
        e_dat = m_data;
        e_sel = 2'(m_sel);
    endtask

    typedef struct {
        logic [3:0]  v;
        logic        r;
        logic [3:0]  rdy;
        logic        val;
        logic [1:0]  sel;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl[20];
    logic [NC*W-1:0] dconst;

    initial begin
        logic [3:0]      e_rdy;
        logic            e_val;
        logic [31:0]     e_dat;
        logic [1:0]      e_sel;
        logic [3:0]      rv, rl;
        logic            rr;
        logic [NC*W-1:0] rd;

        // Round-robin, backpressure, sparse, ptr=3 with 1001, idle, hold.
        tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
        tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
        tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
        tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
        tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
        tbl[5]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
        tbl[6]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hA1};
        tbl[7]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hA1};
        tbl[8]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hA1};
        tbl[9]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
        tbl[10] = '{4'h4, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
        tbl[11] = '{4'h4, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
        tbl[12] = '{4'h4, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
        tbl[13] = '{4'h9, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
        tbl[14] = '{4'h9, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
        tbl[15] = '{4'h9, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
        tbl[16] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd3, 32'hA3};
        tbl[17] = '{4'h0, 1'b0, 4'b0000, 1'b0, 2'd3, 32'hA3};
        tbl[18] = '{4'hF, 1'b0, 4'b0001, 1'b1, 2'd0, 32'hA0};
        tbl[19] = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0};

        for (int k = 0; k < NC; k++) dconst[k*W +: W] = 32'hA0 + 32'(k);

        // Reset: outputs cleared and ready_o low even with requests pending.
        rst_n   = 1'b0;
        valid_i = 4'hF;
        data_i  = dconst;
        ready_i = 1'b1;
        last_i  = 4'hF;
        #1;
        chk("in_reset ready_o", 64'(ready_o), 64'h0);
        chk("in_reset valid_o", 64'(valid_o), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        valid_i = 4'h0;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].v, dconst, tbl[i].r, 4'hF, tbl[i].rdy, tbl[i].val,
                  tbl[i].dat, tbl[i].sel, $sformatf("vec%0d", i));
        end

        // Reset mid-stream while a beat is held: immediate clear.
        rst_n = 1'b0;
        #1;
        chk("async_rst valid_o", 64'(valid_o), 64'h0);
        chk("async_rst data_o", 64'(data_o), 64'h0);
        chk("async_rst sel_o", 64'(sel_o), 64'h0);
        chk("async_rst ready_o", 64'(ready_o), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        // Pointer was 1 before reset; after release the search starts at 0.
        apply(4'hF, dconst, 1'b1, 4'hF, 4'b0001, 1'b1, 32'hA0, 2'd0, "post_rst");

`ifdef ARB_MUX_LOCK_EN
        // ptr=1: ch1 sends three beats (last on third) while ch0/ch2 request.
        apply(4'h7, dconst, 1'b1, 4'b0101, 4'b0010, 1'b1, 32'hA1, 2'd1, "lock_b0");
        apply(4'h7, dconst, 1'b1, 4'b0101, 4'b0010, 1'b1, 32'hA1, 2'd1, "lock_b1");
        apply(4'h7, dconst, 1'b1, 4'b0111, 4'b0010, 1'b1, 32'hA1, 2'd1, "lock_b2");
        apply(4'h7, dconst, 1'b1, 4'b0111, 4'b0100, 1'b1, 32'hA2, 2'd2, "lock_next");
        apply(4'h7, dconst, 1'b1, 4'b0111, 4'b0001, 1'b1, 32'hA0, 2'd0, "lock_wrap");
`endif

        // Randomized run against the reference model from a fresh reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 400; i++) begin
            rv = 4'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            rl = 4'($urandom);
            for (int k = 0; k < NC; k++) rd[k*W +: W] = $urandom;
            model_step(rv, rd, rr, rl, e_rdy, e_val, e_dat, e_sel);
            apply(rv, rd, rr, rl, e_rdy, e_val, e_dat, e_sel, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
